// File: rtl/tribus_arb_if.sv
// tribus_arb_if: agent request/data bundle and arbiter status for tribus_arb
// Params : WIDTH bus width, NREQ number of agents
// Signals: req   per-agent level request          (master -> slave)
//          din   packed agent words, i at [i*WIDTH] (master -> slave)
//          grant one-hot registered ownership       (slave -> master)
//          bus_q registered sample of the bus        (slave -> master)
//          busy  arbiter not idle                    (slave -> master)
interface tribus_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      bus_q;
  logic                  busy;
  modport master (output req, din, input grant, bus_q, busy);
  modport slave (input req, din, output grant, bus_q, busy);
endinterface

// File: rtl/tribus_arb.sv
// tribus_arb: round-robin arbitrated shared tristate bus driver with turnaround gap
// Params : WIDTH bus width, NREQ agents, TURN extra Z cycles after release,
//          MAXHOLD ownership limit (only with TRIBUS_PREEMPT_EN defined)
// Ports  : clk, rst_n (synchronous, active low)
//          p   tribus_arb_if.slave: req, din in; grant, bus_q, busy out
//          bus shared tristate bus, driven from the owner's din slice
// Option : `define TRIBUS_PREEMPT_EN to release an owner after MAXHOLD cycles
//          when another agent is requesting
// bus stays a plain inout so the tristate driver sits on a module port.
module tribus_arb #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tribus_arb_if.slave      p,
  inout  wire  [WIDTH-1:0] bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  if (WIDTH < 1 || WIDTH > 32 || NREQ < 2 || NREQ > 8 || TURN < 0 || TURN > 15 ||
      MAXHOLD < 1 || MAXHOLD > 255) begin : g_bad_param
    $error("tribus_arb: parameter out of range");
  end
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;
  state_t           r_state;
  logic [NREQ-1:0]  r_grant;
  logic [IW-1:0]    r_last;
  logic [3:0]       r_turn;
  logic [WIDTH-1:0] r_bus_q;
  logic             r_busy;
  logic [IW-1:0]    w_win;
  logic             w_rel;
`ifdef TRIBUS_PREEMPT_EN
  logic [7:0]       r_hold;
`endif
  // Scan from farthest to nearest so the last hit is the first agent after r_last.
  always_comb begin
    w_win = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      int j;
      j = (int'(r_last) + k) % NREQ;
      if (p.req[j[IW-1:0]]) w_win = j[IW-1:0];
    end
  end
  // r_last doubles as the owner index while a grant is held.
`ifdef TRIBUS_PREEMPT_EN
  assign w_rel = !p.req[r_last] || (r_hold == 8'(MAXHOLD) && |(p.req & ~r_grant));
`else
  assign w_rel = !p.req[r_last];
`endif
  // Drive enable comes only from the grant flops; data follows din combinationally.
  assign bus     = |r_grant ? p.din[int'(r_last)*WIDTH +: WIDTH] : {WIDTH{1'bz}};
  assign p.grant = r_grant;
  assign p.bus_q = r_bus_q;
  assign p.busy  = r_busy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NREQ - 1);
      r_turn  <= '0;
      r_busy  <= 1'b0;
      r_bus_q <= '0;
`ifdef TRIBUS_PREEMPT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_bus_q <= bus;
      case (r_state)
        S_IDLE: if (|p.req) begin
          r_state <= S_OWN;
          r_grant <= NREQ'(1) << w_win;
          r_last  <= w_win;
          r_busy  <= 1'b1;
`ifdef TRIBUS_PREEMPT_EN
          r_hold  <= 8'd1;
`endif
        end
        S_OWN: begin
          if (w_rel) begin
            r_grant <= '0;
            r_turn  <= 4'(TURN);
            r_state <= TURN == 0 ? S_IDLE : S_TURN;
            r_busy  <= TURN != 0;
          end
`ifdef TRIBUS_PREEMPT_EN
          else if (r_hold != 8'(MAXHOLD)) r_hold <= r_hold + 8'd1;
`endif
        end
        S_TURN: begin
          r_turn <= r_turn - 4'd1;
          if (r_turn == 4'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
